// File: rtl/pipe_ctl_pkg.sv
// Shared state encoding for the pipeline run controller.
package pipe_ctl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } run_state_e;

endpackage

// File: rtl/pipe_run_ctl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, hold-time debounce counter and
// rising-edge press detector on the accepted (stable) level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_reg    <= 1'b0;
      sync2_reg    <= 1'b0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      sync1_reg    <= i_btn;
      sync2_reg    <= sync1_reg;
      stable_d_reg <= stable_reg;
      // Any return to the stable level restarts the hold window.
      if (sync2_reg != stable_reg) begin
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= sync2_reg;
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign o_press = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/pipe_run_ctl.sv
// Run/step/burst sequencer driving the datapath clock enable.
// Burst support is compiled in only when PIPE_RUN_CTL_BURST_EN is defined.
module pipe_run_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32,
  parameter int BURST_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_btn_run,
  input  logic               i_btn_step,
  input  logic               i_btn_burst,
  input  logic [BURST_W-1:0] i_burst_len,
  input  logic               i_halt_req,
  output logic               o_clk_en,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_cycle_cnt,
  output logic               o_halt_ack
);

  run_state_e       state_reg, state_next;
  logic             run_press, step_press;
  logic             halt_prev_reg, halt_evt;
  logic             halt_ack_reg, halt_ack_next;
  logic [CNT_W-1:0] cycle_cnt_reg;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_run), .o_press(run_press)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_step), .o_press(step_press)
  );

`ifdef PIPE_RUN_CTL_BURST_EN
  logic               burst_press;
  logic [BURST_W-1:0] remaining_reg, remaining_next;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_burst_db (
    .i_clk(i_clk), .i_rst(i_rst), .i_btn(i_btn_burst), .o_press(burst_press)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) remaining_reg <= '0;
    else        remaining_reg <= remaining_next;
  end
`else
  logic unused_burst;
  assign unused_burst = ^{i_btn_burst, i_burst_len};
`endif

  assign halt_evt = i_halt_req & ~halt_prev_reg;

  always_comb begin
    state_next    = state_reg;
    halt_ack_next = 1'b0;
`ifdef PIPE_RUN_CTL_BURST_EN
    remaining_next = remaining_reg;
`endif
    case (state_reg)
      ST_HALT: begin
        if (run_press)       state_next = ST_RUN;
        else if (step_press) state_next = ST_STEP;
`ifdef PIPE_RUN_CTL_BURST_EN
        else if (burst_press && (i_burst_len != '0)) begin
          state_next     = ST_BURST;
          remaining_next = i_burst_len;
        end
`endif
      end
      ST_RUN: begin
        if (halt_evt) begin
          state_next    = ST_HALT;
          halt_ack_next = 1'b1;
        end else if (run_press) begin
          state_next = ST_HALT;
        end
      end
      ST_STEP: state_next = ST_HALT;
`ifdef PIPE_RUN_CTL_BURST_EN
      ST_BURST: begin
        if (halt_evt) begin
          state_next    = ST_HALT;
          halt_ack_next = 1'b1;
        end else if (run_press) begin
          state_next = ST_HALT;
        end else if (remaining_reg == BURST_W'(1)) begin
          state_next = ST_HALT;
        end else begin
          remaining_next = remaining_reg - BURST_W'(1);
        end
      end
`endif
      default: state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_reg     <= ST_HALT;
      halt_prev_reg <= 1'b0;
      halt_ack_reg  <= 1'b0;
      cycle_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      halt_prev_reg <= i_halt_req;
      halt_ack_reg  <= halt_ack_next;
      if (o_clk_en) cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
    end
  end

  assign o_clk_en    = (state_reg != ST_HALT);
  assign o_state     = state_reg;
  assign o_cycle_cnt = cycle_cnt_reg;
  assign o_halt_ack  = halt_ack_reg;

endmodule

// File: tb/tb_pipe_run_ctl.sv
// Directed bench for pipe_run_ctl with DEBOUNCE_CYCLES=4 and a 4-bit counter.
module tb_pipe_run_ctl;

  localparam int DB  = 4;
  localparam int CW  = 4;
  localparam int BW  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          btn_run, btn_step, btn_burst, halt_req;
  logic [BW-1:0] burst_len;
  logic          clk_en, halt_ack;
  logic [1:0]    state;
  logic [CW-1:0] cycle_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  pipe_run_ctl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .BURST_W(BW)) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_btn_run(btn_run), .i_btn_step(btn_step), .i_btn_burst(btn_burst),
    .i_burst_len(burst_len), .i_halt_req(halt_req),
    .o_clk_en(clk_en), .o_state(state), .o_cycle_cnt(cycle_cnt),
    .o_halt_ack(halt_ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    btn_run = 0; btn_step = 0; btn_burst = 0; halt_req = 0; burst_len = '0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (state !== 2'd0) begin tests_failed++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests_run++;
    if (clk_en !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_en: got %b expected 0", clk_en); end
    tests_run++;
    if (cycle_cnt !== 4'd0) begin tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", cycle_cnt); end
    $display("[TB] reset done: state=%0d clk_en=%b cnt=%0d", state, clk_en, cycle_cnt);
  endtask

  // Raw edge set after edge e0 is settled before k=e0+1; state moves at k+6.
  task automatic test_step();
    apply_reset();
    btn_step = 1;
    tick(6);
    tests_run++;
    if (clk_en !== 1'b0) begin tests_failed++; $display("FAIL step_early: clk_en got %b expected 0", clk_en); end
    tick(1);
    tests_run++;
    if (state !== 2'd2 || clk_en !== 1'b1) begin
      tests_failed++; $display("FAIL step_enter: state=%0d clk_en=%b expected 2/1", state, clk_en);
    end
    tick(1);
    tests_run++;
    if (state !== 2'd0 || clk_en !== 1'b0 || cycle_cnt !== 4'd1) begin
      tests_failed++; $display("FAIL step_exit: state=%0d clk_en=%b cnt=%0d expected 0/0/1", state, clk_en, cycle_cnt);
    end
    tick(12);
    btn_step = 0;
    tick(10);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd1) begin
      tests_failed++; $display("FAIL step_hold: state=%0d cnt=%0d expected 0/1", state, cycle_cnt);
    end
    $display("[TB] step: cnt=%0d", cycle_cnt);
  endtask

  task automatic test_glitch();
    apply_reset();
    btn_run = 1;
    tick(3);
    btn_run = 0;
    tick(10);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL glitch: state=%0d cnt=%0d expected 0/0", state, cycle_cnt);
    end
    $display("[TB] glitch: state=%0d cnt=%0d", state, cycle_cnt);
  endtask

  task automatic test_run_halt();
    apply_reset();
    btn_run = 1;
    tick(7);
    btn_run = 0;
    tests_run++;
    if (state !== 2'd1 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL run_enter: state=%0d cnt=%0d expected 1/0", state, cycle_cnt);
    end
    tick(10);
    tests_run++;
    if (cycle_cnt !== 4'd10 || clk_en !== 1'b1) begin
      tests_failed++; $display("FAIL run_count: cnt=%0d clk_en=%b expected 10/1", cycle_cnt, clk_en);
    end
    halt_req = 1;
    tick(1);
    tests_run++;
    if (state !== 2'd0 || clk_en !== 1'b0 || halt_ack !== 1'b1 || cycle_cnt !== 4'd11) begin
      tests_failed++;
      $display("FAIL halt_stop: state=%0d clk_en=%b ack=%b cnt=%0d expected 0/0/1/11", state, clk_en, halt_ack, cycle_cnt);
    end
    tick(1);
    tests_run++;
    if (halt_ack !== 1'b0 || cycle_cnt !== 4'd11) begin
      tests_failed++; $display("FAIL halt_ack_pulse: ack=%b cnt=%0d expected 0/11", halt_ack, cycle_cnt);
    end
    halt_req = 0;
    $display("[TB] run/halt: cnt=%0d", cycle_cnt);
  endtask

  task automatic test_async_reset();
    apply_reset();
    btn_run = 1;
    tick(7);
    btn_run = 0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (state !== 2'd0 || clk_en !== 1'b0 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL async_reset: state=%0d clk_en=%b cnt=%0d expected 0/0/0", state, clk_en, cycle_cnt);
    end
    tick(2);
    rst_n = 1'b1;
    tick(10);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL no_resume: state=%0d cnt=%0d expected 0/0", state, cycle_cnt);
    end
    $display("[TB] async reset: state=%0d", state);
  endtask

  task automatic test_wrap();
    apply_reset();
    btn_run = 1;
    tick(7);
    btn_run = 0;
    tick(17);
    tests_run++;
    if (cycle_cnt !== 4'd1 || state !== 2'd1) begin
      tests_failed++; $display("FAIL wrap: cnt=%0d state=%0d expected 1/1", cycle_cnt, state);
    end
    $display("[TB] wrap: cnt=%0d", cycle_cnt);
  endtask

`ifdef PIPE_RUN_CTL_BURST_EN
  task automatic test_burst();
    apply_reset();
    burst_len = 8'd5;
    btn_burst = 1;
    tick(7);
    tests_run++;
    if (state !== 2'd3 || clk_en !== 1'b1) begin
      tests_failed++; $display("FAIL burst_enter: state=%0d clk_en=%b expected 3/1", state, clk_en);
    end
    tick(4);
    tests_run++;
    if (state !== 2'd3 || cycle_cnt !== 4'd4) begin
      tests_failed++; $display("FAIL burst_mid: state=%0d cnt=%0d expected 3/4", state, cycle_cnt);
    end
    tick(1);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd5) begin
      tests_failed++; $display("FAIL burst_end: state=%0d cnt=%0d expected 0/5", state, cycle_cnt);
    end
    btn_burst = 0;
    $display("[TB] burst len 5: cnt=%0d", cycle_cnt);
  endtask

  task automatic test_burst_edges();
    apply_reset();
    burst_len = 8'd0;
    btn_burst = 1;
    tick(12);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL burst_len0: state=%0d cnt=%0d expected 0/0", state, cycle_cnt);
    end
    apply_reset();
    burst_len = 8'd20;
    btn_burst = 1;
    tick(2);
    btn_run = 1;
    tick(6);
    tests_run++;
    if (state !== 2'd3 || cycle_cnt !== 4'd1) begin
      tests_failed++; $display("FAIL abort_pre: state=%0d cnt=%0d expected 3/1", state, cycle_cnt);
    end
    tick(1);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd2) begin
      tests_failed++; $display("FAIL burst_abort: state=%0d cnt=%0d expected 0/2", state, cycle_cnt);
    end
    tick(10);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd2) begin
      tests_failed++; $display("FAIL abort_stays: state=%0d cnt=%0d expected 0/2", state, cycle_cnt);
    end
    btn_run = 0; btn_burst = 0;
    $display("[TB] burst edges: cnt=%0d", cycle_cnt);
  endtask
`else
  task automatic test_burst_disabled();
    apply_reset();
    burst_len = 8'd5;
    btn_burst = 1;
    tick(14);
    tests_run++;
    if (state !== 2'd0 || cycle_cnt !== 4'd0) begin
      tests_failed++; $display("FAIL burst_ignored: state=%0d cnt=%0d expected 0/0", state, cycle_cnt);
    end
    btn_burst = 0;
    $display("[TB] burst disabled: state=%0d", state);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    btn_run = 0; btn_step = 0; btn_burst = 0; halt_req = 0; burst_len = '0;
    test_reset();
    test_step();
    test_glitch();
    test_run_halt();
    test_async_reset();
    test_wrap();
`ifdef PIPE_RUN_CTL_BURST_EN
    test_burst();
    test_burst_edges();
`else
    test_burst_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
